falling_obj_ctl: RTL and testbench
==================================

// Module: falling_obj_ctl
// PURPOSE
//  Gravity controller for one on-screen object. Successor of the click-to-drop rectangle controller.
//  Idle: object follows the mouse. Left-click: object is released and falls with integer gravity.
//  At the floor it bounces with damping, then comes to rest. A second click re-arms it.
//  Sits between mouse_ctl (position/buttons, already in clk domain) and draw_rect (xpos/ypos consumer).
// PARAMETERS
//  W          12       width of all position/velocity signals
//  TICK_DIV   400_000  clk cycles per physics tick (40 MHz -> 100 Hz)
//  FLOOR_Y    534      lowest allowed ypos (object top at rest)
//  GRAVITY    1        px/tick added to velocity every tick
//  VEL_MAX    64       fall-velocity saturation, px/tick
//  DAMP_SHIFT 1        bounce: v_up = v - (v >> DAMP_SHIFT)
//  MIN_BOUNCE 4        impact velocity below this -> no bounce, object lands
// PORTS
//  clk         in   1  pixel clock, 40 MHz
//  rst         in   1  reset, asynchronous, active-high
//  mouse_left  in   1  left button level, synchronous to clk
//  mouse_xpos  in   W  mouse x
//  mouse_ypos  in   W  mouse y
//  xpos        out  W  object x, registered
//  ypos        out  W  object y, registered
//  busy        out  1  high in FALL/RISE
//  landed      out  1  one-cycle pulse on entry to REST
// BEHAVIOUR
//  Reset (async): state=IDLE; xpos=0, ypos=0, vel=0, busy=0, landed=0; tick counter=0; click edge reg=0.
//  click = mouse_left & ~mouse_left_q (rising edge). Levels held longer than one cycle are ignored.
//  Tick counter: cleared on every state entry; tick pulses after exactly TICK_DIV cycles, then each TICK_DIV.
//  IDLE:
//   - xpos<=mouse_xpos, ypos<=min(mouse_ypos,FLOOR_Y) every cycle (1-cycle latency).
//   - On click: xpos frozen; vel<=0; go to FALL. If mouse_ypos>=FLOOR_Y, go to REST with ypos=FLOOR_Y.
//  FALL, on tick:
//   - v' = min(vel+GRAVITY, VEL_MAX); vel<=v'.
//   - If ypos+v' >= FLOOR_Y (compute at W+1 bits): ypos<=FLOOR_Y.
//     - If v' >= MIN_BOUNCE: vel<=v'-(v'>>DAMP_SHIFT); go to RISE.
//     - Else: vel<=0; go to REST.
//   - Else: ypos<=ypos+v'.
//  RISE, on tick:
//   - ypos<=sat0(ypos-vel), i.e. clamp at 0 on underflow.
//   - vel<=vel-GRAVITY. When vel<=GRAVITY, vel<=0 and go to FALL (apex).
//  REST:
//   - ypos=FLOOR_Y held; landed=1 on the first cycle only.
//   - On click: go to IDLE (re-track from the next cycle).
//  Clicks during FALL/RISE are ignored. xpos never changes outside IDLE.
//  Reset mid-flight: immediate return to IDLE state and reset values; no landed pulse.
//  busy is combinational from state: (state==FALL)|(state==RISE).
//  All arithmetic is unsigned. vel never exceeds VEL_MAX and never wraps.
// STRUCTURE
//  vga_pkg: typedef enum logic [1:0] {IDLE,FALL,RISE,REST} obj_state_t; localparam FLOOR_Y default.
//  Sub-module tick_gen #(TICK_DIV): counter with sync clear input, outputs 1-cycle tick.
//  Top: edge detect, state register, vel/ypos datapath. All registers use async rst.
// TESTING  (TICK_DIV=4, other defaults, mouse_xpos=200, mouse_ypos=0)
//  1. Reset mid-sim: xpos=ypos=0, busy=0, landed=0 during rst; after release, IDLE tracks mouse -> xpos=200, ypos=0.
//  2. Click (held 21 cycles): busy=1; ypos 1,3,6,10,... each 4 clk; xpos stays 200; 2nd edge ignored.
//  3. Impact: tick 32 ypos=528 vel=32; tick 33 ypos=534, vel=17, state RISE; tick 34 ypos=517.
//  4. Bounces decay; final impact with v'<4 -> REST; exactly one landed pulse; ypos=534 held; busy=0.
//  5. Click in IDLE with mouse_ypos=600 -> REST immediately; ypos=534; landed pulse.
//  6. Click in REST -> IDLE; ypos follows mouse_ypos next cycle.
//  7. Assert rst during RISE -> all outputs 0 asynchronously; no landed pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and defaults for the on-screen object controllers.
// Imported by the gravity controller and its helpers.
package vga_pkg;

    typedef enum logic [1:0] {IDLE, FALL, RISE, REST} obj_state_t;

    localparam int FLOOR_Y_DEF = 534;

endpackage

// File: rtl/falling_obj_ctl_tick_gen.sv
// tick_gen: physics tick divider; o_tick is high for one cycle every TICK_DIV cycles.
// i_clr restarts the period so the first tick lands exactly TICK_DIV cycles later.
module tick_gen #(
    parameter int TICK_DIV = 400_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/falling_obj_ctl.sv
// falling_obj_ctl: mouse-following object that drops on left-click,
// falls under integer gravity, bounces with damping and comes to rest.
module falling_obj_ctl
    import vga_pkg::*;
#(
    parameter int W          = 12,
    parameter int TICK_DIV   = 400_000,
    parameter int FLOOR_Y    = FLOOR_Y_DEF,
    parameter int GRAVITY    = 1,
    parameter int VEL_MAX    = 64,
    parameter int DAMP_SHIFT = 1,
    parameter int MIN_BOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mouse_left,
    input  logic [W-1:0] mouse_xpos,
    input  logic [W-1:0] mouse_ypos,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic         busy,
    output logic         landed
);

    localparam logic [W-1:0] FLOOR  = W'(FLOOR_Y);
    localparam logic [W-1:0] GRAV   = W'(GRAVITY);
    localparam logic [W-1:0] VMAX   = W'(VEL_MAX);
    localparam logic [W-1:0] VBOUNC = W'(MIN_BOUNCE);

    obj_state_t r_state, w_next;
    logic r_left_q, r_landed;
    logic [W-1:0] r_xpos, r_ypos, r_vel;
    logic [W-1:0] w_xpos, w_ypos, w_vel;
    logic [W-1:0] w_vnew, w_vdamp;
    logic [W:0] w_vsum, w_ysum, w_ydiff;
    logic w_click, w_tick, w_clr;

    assign w_click = mouse_left & ~r_left_q;
    // Any state change restarts the tick period
    assign w_clr = (w_next != r_state);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // One extra bit keeps velocity and position sums from wrapping
    assign w_vsum  = {1'b0, r_vel} + {1'b0, GRAV};
    assign w_vnew  = (w_vsum >= {1'b0, VMAX}) ? VMAX : w_vsum[W-1:0];
    assign w_vdamp = w_vnew - (w_vnew >> DAMP_SHIFT);
    assign w_ysum  = {1'b0, r_ypos} + {1'b0, w_vnew};
    assign w_ydiff = {1'b0, r_ypos} - {1'b0, r_vel};

    always_comb begin
        w_next = r_state;
        w_xpos = r_xpos;
        w_ypos = r_ypos;
        w_vel  = r_vel;
        unique case (r_state)
            IDLE: begin
                if (w_click) begin
                    w_vel = '0;
                    if (mouse_ypos >= FLOOR) begin
                        w_ypos = FLOOR;
                        w_next = REST;
                    end else begin
                        w_next = FALL;
                    end
                end else begin
                    w_xpos = mouse_xpos;
                    w_ypos = (mouse_ypos < FLOOR) ? mouse_ypos : FLOOR;
                end
            end
            FALL: begin
                if (w_tick) begin
                    if (w_ysum >= {1'b0, FLOOR}) begin
                        w_ypos = FLOOR;
                        if (w_vnew >= VBOUNC) begin
                            w_vel  = w_vdamp;
                            w_next = RISE;
                        end else begin
                            w_vel  = '0;
                            w_next = REST;
                        end
                    end else begin
                        w_ypos = w_ysum[W-1:0];
                        w_vel  = w_vnew;
                    end
                end
            end
            RISE: begin
                if (w_tick) begin
                    w_ypos = w_ydiff[W] ? '0 : w_ydiff[W-1:0];
                    if (r_vel <= GRAV) begin
                        w_vel  = '0;
                        w_next = FALL;
                    end else begin
                        w_vel = r_vel - GRAV;
                    end
                end
            end
            REST: begin
                w_ypos = FLOOR;
                w_vel  = '0;
                if (w_click) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_left_q <= 1'b0;
            r_xpos   <= '0;
            r_ypos   <= '0;
            r_vel    <= '0;
            r_landed <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_left_q <= mouse_left;
            r_xpos   <= w_xpos;
            r_ypos   <= w_ypos;
            r_vel    <= w_vel;
            r_landed <= (w_next == REST) && (r_state != REST);
        end
    end

    assign xpos   = r_xpos;
    assign ypos   = r_ypos;
    assign busy   = (r_state == FALL) || (r_state == RISE);
    assign landed = r_landed;

endmodule

// File: tb/tb_falling_obj_ctl.sv
// tb_falling_obj_ctl: drives clicks and mouse motion, checks the object
// trajectory against a per-tick gravity/bounce model kept in the bench.
module tb_falling_obj_ctl;

    localparam int W     = 12;
    localparam int TD    = 4;
    localparam int FLOOR = 534;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mouse_left = 1'b0;
    logic [W-1:0] mouse_xpos = 12'd200;
    logic [W-1:0] mouse_ypos = 12'd0;
    logic [W-1:0] xpos, ypos;
    logic         busy, landed;

    int checks = 0;
    int errors = 0;

    // model: phase 0 = falling, 1 = rising, 2 = resting
    int m_y, m_v, m_ph, m_ticks;

    always #5 clk = ~clk;

    falling_obj_ctl #(.W(W), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy),
        .landed     (landed)
    );

    task automatic ref_tick();
        if (m_ph == 0) begin
            m_v = (m_v + 1 > 64) ? 64 : m_v + 1;
            if (m_y + m_v >= FLOOR) begin
                m_y = FLOOR;
                if (m_v >= 4) begin
                    m_v  = m_v - m_v / 2;
                    m_ph = 1;
                end else begin
                    m_v  = 0;
                    m_ph = 2;
                end
            end else begin
                m_y = m_y + m_v;
            end
        end else if (m_ph == 1) begin
            m_y = (m_y > m_v) ? m_y - m_v : 0;
            if (m_v <= 1) begin
                m_v  = 0;
                m_ph = 0;
            end else begin
                m_v = m_v - 1;
            end
        end
        m_ticks++;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (xpos !== 0 || ypos !== 0 || busy !== 0 || landed !== 0) begin
            errors++;
            $display("FAIL reset_hold x=%0d y=%0d busy=%b landed=%b want all 0",
                     xpos, ypos, busy, landed);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (xpos !== 200 || ypos !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_track x=%0d y=%0d busy=%b want 200 0 0",
                     xpos, ypos, busy);
        end
    endtask

    // Drop from y0 and follow the whole flight to rest.
    task automatic test_flight(input int y0, input bit det);
        int cyc;
        int xs;
        bit tick;
        mouse_left = 1'b0;
        if (!det) mouse_xpos = W'($urandom_range(0, 4095));
        mouse_ypos = W'(y0);
        xs = int'(mouse_xpos);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ypos !== W'(y0) || xpos !== W'(xs)) begin
            errors++;
            $display("FAIL idle_track x=%0d y=%0d want %0d %0d", xpos, ypos, xs, y0);
        end
        mouse_left = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL click_busy busy=%b want 1", busy);
        end
        m_y = y0; m_v = 0; m_ph = 0; m_ticks = 0; cyc = 0;
        while (m_ph != 2 && cyc < 3000) begin
            if (det) begin
                mouse_left = (cyc < 20) || (cyc >= 30 && cyc < 32);
            end else begin
                mouse_left = 1'($urandom_range(0, 1));
                mouse_xpos = W'($urandom_range(0, 4095));
                mouse_ypos = W'($urandom_range(0, 4095));
            end
            @(posedge clk);
            #1;
            cyc++;
            tick = (cyc % TD == 0);
            if (tick) ref_tick();
            checks++;
            if (ypos !== W'(m_y) || xpos !== W'(xs) || busy !== (m_ph != 2)
                || landed !== (tick && m_ph == 2)) begin
                errors++;
                $display("FAIL flight cyc=%0d x=%0d y=%0d busy=%b landed=%b want %0d %0d %b %b",
                         cyc, xpos, ypos, busy, landed, xs, m_y, m_ph != 2,
                         tick && m_ph == 2);
            end
            if (det && tick && (m_ticks == 32 || m_ticks == 33 || m_ticks == 34)) begin
                checks++;
                if ((m_ticks == 32 && ypos !== 12'd528) ||
                    (m_ticks == 33 && ypos !== 12'd534) ||
                    (m_ticks == 34 && ypos !== 12'd517)) begin
                    errors++;
                    $display("FAIL impact tick=%0d y=%0d", m_ticks, ypos);
                end
            end
        end
        mouse_left = 1'b0;
        if (m_ph != 2) begin
            errors++;
            $display("FAIL flight_timeout no rest after %0d cycles", cyc);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (ypos !== FLOOR || busy !== 0 || landed !== 0 || xpos !== W'(xs)) begin
                errors++;
                $display("FAIL rest_hold x=%0d y=%0d busy=%b landed=%b want %0d 534 0 0",
                         xpos, ypos, busy, landed, xs);
            end
        end
    endtask

    task automatic test_rearm();
        int mx, my, ey;
        mx = $urandom_range(0, 4095);
        my = $urandom_range(0, 700);
        ey = (my < FLOOR) ? my : FLOOR;
        mouse_left = 1'b0;
        @(posedge clk);
        #1;
        mouse_left = 1'b1;
        mouse_xpos = W'(mx);
        mouse_ypos = W'(my);
        @(posedge clk);
        #1;
        mouse_left = 1'b0;
        checks++;
        if (busy !== 0 || landed !== 0 || ypos !== FLOOR) begin
            errors++;
            $display("FAIL rearm_edge y=%0d busy=%b landed=%b want 534 0 0",
                     ypos, busy, landed);
        end
        @(posedge clk);
        #1;
        checks++;
        if (xpos !== W'(mx) || ypos !== W'(ey)) begin
            errors++;
            $display("FAIL rearm_track x=%0d y=%0d want %0d %0d", xpos, ypos, mx, ey);
        end
    endtask

    task automatic test_click_floor();
        mouse_ypos = W'($urandom_range(FLOOR, 4095));
        @(posedge clk);
        #1;
        mouse_left = 1'b1;
        @(posedge clk);
        #1;
        mouse_left = 1'b0;
        checks++;
        if (ypos !== FLOOR || landed !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL floor_click y=%0d landed=%b busy=%b want 534 1 0",
                     ypos, landed, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ypos !== FLOOR || landed !== 0) begin
            errors++;
            $display("FAIL floor_pulse y=%0d landed=%b want 534 0", ypos, landed);
        end
    endtask

    task automatic test_reset_flight();
        int cyc;
        mouse_left = 1'b0;
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd520;
        repeat (2) @(posedge clk);
        #1;
        mouse_left = 1'b1;
        @(posedge clk);
        #1;
        mouse_left = 1'b0;
        m_y = 520; m_v = 0; m_ph = 0; m_ticks = 0; cyc = 0;
        while (m_ph != 1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc % TD == 0) ref_tick();
        end
        checks++;
        if (busy !== 1 || ypos !== W'(m_y)) begin
            errors++;
            $display("FAIL rise_entry y=%0d busy=%b want %0d 1", ypos, busy, m_y);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (xpos !== 0 || ypos !== 0 || busy !== 0 || landed !== 0) begin
            errors++;
            $display("FAIL async_reset x=%0d y=%0d busy=%b landed=%b want all 0",
                     xpos, ypos, busy, landed);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (landed !== 0 || busy !== 0 || ypos !== 0) begin
                errors++;
                $display("FAIL reset_held y=%0d busy=%b landed=%b want 0 0 0",
                         ypos, busy, landed);
            end
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (xpos !== 300 || ypos !== 520 || landed !== 0) begin
            errors++;
            $display("FAIL post_reset x=%0d y=%0d landed=%b want 300 520 0",
                     xpos, ypos, landed);
        end
    endtask

    initial begin
        test_reset();
        test_flight(0, 1'b1);
        test_rearm();
        test_click_floor();
        test_rearm();
        repeat (3) begin
            test_flight($urandom_range(0, FLOOR - 1), 1'b0);
            test_rearm();
        end
        test_flight(FLOOR - 1, 1'b0);
        test_rearm();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
